tmds_encoder: RTL and testbench

TMDS_ENCODER -- requirements
Module: tmds_encoder

---
 rtl/tmds_encoder.sv | 118 +++++++++++
 tb/tb_tmds_encoder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - two-stage TMDS 8b/10b symbol encoder with running disparity
module tmds_encoder #(
    parameter logic INVERT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       de,
    input  logic [1:0] ctl,
    input  logic [7:0] d,
    output logic [9:0] q,
    output logic [4:0] dbg_disparity
);

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Stage 1 registers: transition-minimised word plus pipelined de/ctl
    logic       de1_q, de1_d;
    logic [1:0] ctl1_q, ctl1_d;
    logic [8:0] qm_q, qm_d;

    // Stage 2 registers: output symbol and running disparity
    logic [9:0] q_q, q_d;
    logic [4:0] cnt_q, cnt_d;

    // Stage 1: choose XOR/XNOR chain from the ones count of d and build q_m
    always_comb begin
        logic [3:0] n1;
        logic       use_xnor;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        qm_d     = 9'd0;
        qm_d[0]  = d[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ d[i]) : (qm_d[i-1] ^ d[i]);
        end
        qm_d[8] = ~use_xnor;
        de1_d   = de;
        ctl1_d  = ctl;
    end

    // Stage 2: DC-balance the data word against the running disparity, or emit a control token
    always_comb begin
        logic [3:0]        n1_m;
        logic signed [5:0] cnt_ext;
        logic signed [5:0] diff;
        logic signed [5:0] cnt_new;
        logic [9:0]        sym;
        logic              qm8;

        n1_m    = popcount8(qm_q[7:0]);
        cnt_ext = $signed({cnt_q[4], cnt_q});
        // N1 - N0 == 2*N1 - 8
        diff    = $signed({1'b0, n1_m, 1'b0}) - 6'sd8;
        qm8     = qm_q[8];
        sym     = 10'd0;
        cnt_new = 6'sd0;

        if (de1_q) begin
            if ((cnt_ext == 6'sd0) || (diff == 6'sd0)) begin
                sym     = {~qm8, qm8, (qm8 ? qm_q[7:0] : ~qm_q[7:0])};
                cnt_new = qm8 ? (cnt_ext + diff) : (cnt_ext - diff);
            end else if (((cnt_ext > 6'sd0) && (diff > 6'sd0)) ||
                         ((cnt_ext < 6'sd0) && (diff < 6'sd0))) begin
                sym     = {1'b1, qm8, ~qm_q[7:0]};
                cnt_new = cnt_ext + (qm8 ? 6'sd2 : 6'sd0) - diff;
            end else begin
                sym     = {1'b0, qm8, qm_q[7:0]};
                cnt_new = cnt_ext + diff - (qm8 ? 6'sd0 : 6'sd2);
            end
        end else begin
            // Control periods restart the disparity from zero
            unique case (ctl1_q)
                2'b00:   sym = TOK_00;
                2'b01:   sym = TOK_01;
                2'b10:   sym = TOK_10;
                default: sym = TOK_11;
            endcase
            cnt_new = 6'sd0;
        end

        // Lane polarity swap is applied to the wire value only, never to the disparity
        q_d   = sym ^ {10{INVERT}};
        cnt_d = cnt_new[4:0];
    end

    // Pipeline registers with synchronous active-low reset flushing both stages
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de1_q  <= 1'b0;
            ctl1_q <= 2'b00;
            qm_q   <= 9'd0;
            q_q    <= TOK_00 ^ {10{INVERT}};
            cnt_q  <= 5'd0;
        end else begin
            de1_q  <= de1_d;
            ctl1_q <= ctl1_d;
            qm_q   <= qm_d;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q             = q_q;
    assign dbg_disparity = cnt_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// tb/tb_tmds_encoder.sv - randomized self-checking bench for tmds_encoder against a behavioural model
module tb_tmds_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       de;
    logic [1:0] ctl;
    logic [7:0] d;
    logic [9:0] q, q_inv;
    logic [4:0] dbg, dbg_inv;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] tok [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    // model state: inputs captured by the last edge, and the symbol now expected on q
    logic       p_de;
    logic [1:0] p_ctl;
    logic [7:0] p_d;
    int         m_cnt;
    logic [9:0] exp_q;
    logic       out_de;
    logic [7:0] out_d;

    always #5 clk = ~clk;

    tmds_encoder #(.INVERT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .de(de), .ctl(ctl), .d(d),
        .q(q), .dbg_disparity(dbg)
    );

    tmds_encoder #(.INVERT(1'b1)) dut_inv (
        .clk(clk), .rst_n(rst_n), .de(de), .ctl(ctl), .d(d),
        .q(q_inv), .dbg_disparity(dbg_inv)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ones(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += v[i];
        return n;
    endfunction

    // Encode one data byte from the rules in terms of counts, updating m_cnt
    task automatic model_data(input logic [7:0] dv);
        logic [7:0] m;
        logic       use_xnor;
        int         n1, n0;
        int         delta;
        use_xnor = (ones(dv) > 4) || (ones(dv) == 4 && dv[0] == 1'b0);
        m[0] = dv[0];
        for (int i = 1; i < 8; i++) m[i] = use_xnor ? ~(m[i-1] ^ dv[i]) : (m[i-1] ^ dv[i]);
        n1 = ones(m);
        n0 = 8 - n1;
        if (m_cnt == 0 || n1 == n0) begin
            if (use_xnor) begin exp_q = {2'b10, ~m}; delta = n0 - n1; end
            else          begin exp_q = {2'b01,  m}; delta = n1 - n0; end
        end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
            exp_q = {1'b1, ~use_xnor, ~m};
            delta = (use_xnor ? 0 : 2) + (n0 - n1);
        end else begin
            exp_q = {1'b0, ~use_xnor, m};
            delta = (n1 - n0) - (use_xnor ? 2 : 0);
        end
        m_cnt = m_cnt + delta;
    endtask

    // Recover the byte from a data symbol without reference to how it was encoded
    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] w, r;
        w = s[9] ? ~s[7:0] : s[7:0];
        r[0] = w[0];
        for (int i = 1; i < 8; i++) r[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
        return r;
    endfunction

    task automatic cycle(input logic r, input logic e, input logic [1:0] c, input logic [7:0] dv);
        int sd;
        rst_n = r; de = e; ctl = c; d = dv;
        @(posedge clk);
        if (!r) begin
            exp_q = tok[0]; m_cnt = 0; out_de = 1'b0;
            p_de = 1'b0; p_ctl = 2'b00; p_d = 8'd0;
        end else begin
            if (p_de) model_data(p_d);
            else begin exp_q = tok[p_ctl]; m_cnt = 0; end
            out_de = p_de; out_d = p_d;
            p_de = e; p_ctl = c; p_d = dv;
        end
        @(negedge clk);
        check("q", {22'd0, q}, {22'd0, exp_q});
        check("q_inverted", {22'd0, q_inv}, {22'd0, ~exp_q});
        check("disparity", {27'd0, dbg}, {27'd0, 5'(m_cnt)});
        check("disparity_inv_lane", {27'd0, dbg_inv}, {27'd0, 5'(m_cnt)});
        sd = int'($signed(dbg));
        check("disparity_range", {31'd0, (sd >= -10 && sd <= 10)}, 32'd1);
        if (out_de) check("decode", {24'd0, decode(q)}, {24'd0, out_d});
    endtask

    task automatic expect_sym(input string tag, input logic [9:0] eq, input int ec);
        check(tag, {22'd0, q}, {22'd0, eq});
        check({tag, "_disp"}, {27'd0, dbg}, {27'd0, 5'(ec)});
    endtask

    initial begin
        rst_n = 1'b0; de = 1'b0; ctl = 2'b00; d = 8'd0;
        m_cnt = 0; exp_q = tok[0]; out_de = 1'b0; out_d = 8'd0;
        p_de = 1'b0; p_ctl = 2'b00; p_d = 8'd0;
        @(negedge clk);

        cycle(1'b0, 1'b1, 2'b11, 8'hA5);
        cycle(1'b0, 1'b1, 2'b11, 8'h5A);
        expect_sym("reset_q", 10'b1101010100, 0);
        check("reset_q_inv", {22'd0, q_inv}, {22'd0, 10'b0010101011});

        cycle(1'b1, 1'b0, 2'b00, 8'h00);
        cycle(1'b1, 1'b0, 2'b01, 8'h00); expect_sym("ctl00", 10'b1101010100, 0);
        cycle(1'b1, 1'b0, 2'b10, 8'h00); expect_sym("ctl01", 10'b0010101011, 0);
        cycle(1'b1, 1'b0, 2'b11, 8'h00); expect_sym("ctl10", 10'b0101010100, 0);
        cycle(1'b1, 1'b1, 2'b00, 8'h00); expect_sym("ctl11", 10'b1010101011, 0);
        cycle(1'b1, 1'b1, 2'b00, 8'h00); expect_sym("zero_a", 10'b0100000000, -8);
        cycle(1'b1, 1'b1, 2'b00, 8'h00); expect_sym("zero_b", 10'b1111111111, 2);
        cycle(1'b1, 1'b0, 2'b00, 8'h00); expect_sym("zero_c", 10'b0100000000, -6);
        cycle(1'b1, 1'b1, 2'b00, 8'h00); expect_sym("switch_tok", 10'b1101010100, 0);
        cycle(1'b1, 1'b0, 2'b00, 8'h00); expect_sym("switch_data", 10'b0100000000, -8);
        cycle(1'b1, 1'b1, 2'b00, 8'hFF); expect_sym("pre_ff_tok", 10'b1101010100, 0);
        cycle(1'b1, 1'b1, 2'b00, 8'h37); expect_sym("ff_xnor", 10'b1000000000, -8);

        // mid-stream reset discards in-flight data
        cycle(1'b0, 1'b1, 2'b00, 8'h12);
        cycle(1'b1, 1'b1, 2'b00, 8'h00); expect_sym("flush_tok", 10'b1101010100, 0);
        cycle(1'b1, 1'b0, 2'b10, 8'h00); expect_sym("flush_first", 10'b0100000000, -8);

        for (int i = 0; i < 4000; i++) begin
            logic rr, ee;
            rr = ($urandom_range(0, 199) != 0);
            ee = ($urandom_range(0, 9) < 8);
            cycle(rr, ee, 2'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
